debug_run_ctrl: RTL

DEBUG_RUN_CTRL -- requirements
Module: debug_run_ctrl

---
 rtl/gb_debug_pkg.sv | 15 +
 rtl/debug_run_ctrl.sv | 108 ++++++++++
 2 files changed

// File: rtl/gb_debug_pkg.sv
// Shared debugger definitions: run-control state encoding decoded by both the
// run controller and the debugger display.
package gb_debug_pkg;

  typedef enum logic [1:0] {
    DBG_RUN  = 2'd0,
    DBG_HALT = 2'd1,
    DBG_STEP = 2'd2,
    DBG_SKIP = 2'd3
  } dbg_state_e;

  localparam int PC_W        = 16;
  localparam int INSTR_CNT_W = 16;

endpackage

// File: rtl/debug_run_ctrl.sv
// Debugger run control for the CPU core: halt/step/continue handling, a single
// PC breakpoint with a saturating hit counter, and a per-halt fetch counter.
module debug_run_ctrl
  import gb_debug_pkg::*;
#(
  parameter bit START_HALTED = 1'b0,
  parameter int BP_CNT_W     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   step_req,
  input  logic                   cont_req,
  input  logic                   halt_req,
  input  logic                   bp_en,
  input  logic [PC_W-1:0]        bp_addr,
  input  logic [PC_W-1:0]        pc,
  input  logic                   fetch,
  output logic                   cpu_halt,
  output logic [1:0]             dbg_state,
  output logic [BP_CNT_W-1:0]    bp_hits,
  output logic [INSTR_CNT_W-1:0] instr_cnt
);

  localparam dbg_state_e RESET_STATE = START_HALTED ? DBG_HALT : DBG_RUN;

  function automatic logic [BP_CNT_W-1:0] sat_inc(input logic [BP_CNT_W-1:0] v);
    return (&v) ? v : v + BP_CNT_W'(1);
  endfunction

  dbg_state_e             state_q, state_d;
  logic                   cpu_halt_q, cpu_halt_d;
  logic [BP_CNT_W-1:0]    bp_hits_q, bp_hits_d;
  logic [INSTR_CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic                   bp_match;
  logic                   bp_hit;
  logic                   enter_halt;

  assign bp_match = fetch && bp_en && (pc == bp_addr);

  always_comb begin
    state_d = state_q;
    bp_hit  = 1'b0;
    case (state_q)
      DBG_RUN: begin
        // A halt request wins over a coincident breakpoint and is not a hit.
        if (halt_req) begin
          state_d = DBG_HALT;
        end else if (bp_match) begin
          state_d = DBG_HALT;
          bp_hit  = 1'b1;
        end
      end
      DBG_HALT: begin
        if (cont_req) begin
          state_d = DBG_SKIP;
        end else if (step_req) begin
          state_d = DBG_STEP;
        end
      end
      DBG_STEP: begin
        if (halt_req || fetch) begin
          state_d = DBG_HALT;
        end
      end
      DBG_SKIP: begin
        // The first fetch after continue is allowed past the breakpoint it stopped on.
        if (halt_req) begin
          state_d = DBG_HALT;
        end else if (fetch) begin
          state_d = DBG_RUN;
        end
      end
      default: state_d = DBG_HALT;
    endcase

    enter_halt = (state_d == DBG_HALT) && (state_q != DBG_HALT);

    instr_cnt_d = instr_cnt_q;
    if (enter_halt) begin
      instr_cnt_d = '0;
    end else if (fetch && (state_q != DBG_HALT)) begin
      instr_cnt_d = instr_cnt_q + INSTR_CNT_W'(1);
    end

    bp_hits_d  = bp_hit ? sat_inc(bp_hits_q) : bp_hits_q;
    cpu_halt_d = (state_d == DBG_HALT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      cpu_halt_q  <= START_HALTED;
      bp_hits_q   <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cpu_halt_q  <= cpu_halt_d;
      bp_hits_q   <= bp_hits_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cpu_halt  = cpu_halt_q;
  assign dbg_state = state_q;
  assign bp_hits   = bp_hits_q;
  assign instr_cnt = instr_cnt_q;

endmodule
